// File: rtl/rb_pkg.sv
// rb_pkg: shared constants and types for the rb_block register-bank stage.
//   - Widths: 8-bit data, 32 registers, 5-bit register address, 24-bit instruction.
//   - Instruction source-register field positions (rs1, rs2).
//   - 2-bit forward-select encodings and the forward mux helper.
package rb_pkg;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned INS_W    = 24;

    localparam int unsigned RS1_HI = 12;
    localparam int unsigned RS1_LO = 8;
    localparam int unsigned RS2_HI = 7;
    localparam int unsigned RS2_LO = 3;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_EX  = 2'b01,
        FWD_DM  = 2'b10,
        FWD_WB  = 2'b11
    } fwd_sel_e;

    // Operand forwarding: pick the register-file value or one of the later-stage results.
    function automatic logic [DATA_W-1:0] fwd_mux(
        input logic [1:0]        sel,
        input logic [DATA_W-1:0] reg_val,
        input logic [DATA_W-1:0] ex_val,
        input logic [DATA_W-1:0] dm_val,
        input logic [DATA_W-1:0] wb_val
    );
        logic [DATA_W-1:0] res;
        res = reg_val;
        case (sel)
            FWD_REG: res = reg_val;
            FWD_EX:  res = ex_val;
            FWD_DM:  res = dm_val;
            FWD_WB:  res = wb_val;
            default: res = reg_val;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/rb_block_regfile.sv
// rb_block_regfile: 32 x 8-bit register array.
//   Optional feature macro: RB_WRITE_BYPASS_EN (write-through reads when the write
//   address matches a read address).
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-low reset; clears every register, no write that edge
//   i_waddr    write address (written unconditionally each edge out of reset)
//   i_wdata    write data
//   i_raddr1   read address, port 1 (combinational)
//   i_raddr2   read address, port 2 (combinational)
//   o_rdata1   read data, port 1
//   o_rdata2   read data, port 2
module rb_block_regfile
    import rb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr1,
    input  logic [ADDR_W-1:0] i_raddr2,
    output logic [DATA_W-1:0] o_rdata1,
    output logic [DATA_W-1:0] o_rdata2
);

    logic [DATA_W-1:0] r_regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

`ifdef RB_WRITE_BYPASS_EN
    // Write-through: a read of the address being written this edge sees the new data.
    always_comb begin
        o_rdata1 = (i_raddr1 == i_waddr) ? i_wdata : r_regs[i_raddr1];
        o_rdata2 = (i_raddr2 == i_waddr) ? i_wdata : r_regs[i_raddr2];
    end
`else
    always_comb begin
        o_rdata1 = r_regs[i_raddr1];
        o_rdata2 = r_regs[i_raddr2];
    end
`endif

endmodule

// File: rtl/rb_block.sv
// rb_block: register-bank and operand-select stage of the 8-bit pipelined processor.
//   Decodes rs1/rs2 from the instruction, reads the register file, applies the
//   forwarding and immediate muxes and registers operands A and B.
//   Optional feature macro: RB_WRITE_BYPASS_EN (register-file write-through reads).
// Ports:
//   clk           rising-edge clock
//   reset         synchronous active-low reset; clears registers, A and B
//   i_ins         instruction; rs1 = [12:8], rs2 = [7:3], other bits ignored
//   i_ans_ex      forwarded execute-stage result
//   i_ans_dm      data-memory-stage result, also the register write data
//   i_ans_wb      forwarded write-back-stage result
//   i_imm         immediate operand
//   i_rw_dm       register write address
//   i_mux_sel_a   A forward select (00 reg, 01 ex, 10 dm, 11 wb)
//   i_mux_sel_b   B forward select (same encoding)
//   i_imm_sel     1: B takes immediate, 0: B takes forwarded value
//   o_a, o_b      registered operands
module rb_block
    import rb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [INS_W-1:0]  i_ins,
    input  logic [DATA_W-1:0] i_ans_ex,
    input  logic [DATA_W-1:0] i_ans_dm,
    input  logic [DATA_W-1:0] i_ans_wb,
    input  logic [DATA_W-1:0] i_imm,
    input  logic [ADDR_W-1:0] i_rw_dm,
    input  logic [1:0]        i_mux_sel_a,
    input  logic [1:0]        i_mux_sel_b,
    input  logic              i_imm_sel,
    output logic [DATA_W-1:0] o_a,
    output logic [DATA_W-1:0] o_b
);

    logic [ADDR_W-1:0] w_rs1;
    logic [ADDR_W-1:0] w_rs2;
    logic [DATA_W-1:0] w_rdata1;
    logic [DATA_W-1:0] w_rdata2;
    logic [DATA_W-1:0] w_a_next;
    logic [DATA_W-1:0] w_b_next;
    logic              w_unused_ins;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;

    assign w_rs1 = i_ins[RS1_HI:RS1_LO];
    assign w_rs2 = i_ins[RS2_HI:RS2_LO];
    assign w_unused_ins = ^{i_ins[INS_W-1:RS1_HI+1], i_ins[RS2_LO-1:0]};

    rb_block_regfile u_regfile (
        .clk      (clk),
        .reset    (reset),
        .i_waddr  (i_rw_dm),
        .i_wdata  (i_ans_dm),
        .i_raddr1 (w_rs1),
        .i_raddr2 (w_rs2),
        .o_rdata1 (w_rdata1),
        .o_rdata2 (w_rdata2)
    );

    always_comb begin
        w_a_next = fwd_mux(i_mux_sel_a, w_rdata1, i_ans_ex, i_ans_dm, i_ans_wb);
        w_b_next = fwd_mux(i_mux_sel_b, w_rdata2, i_ans_ex, i_ans_dm, i_ans_wb);
        if (i_imm_sel) begin
            w_b_next = i_imm;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_a <= '0;
            r_b <= '0;
        end else begin
            r_a <= w_a_next;
            r_b <= w_b_next;
        end
    end

    assign o_a = r_a;
    assign o_b = r_b;

endmodule

// File: tb/tb_rb_block.sv
// tb_rb_block: self-checking bench for rb_block.
//   Directed vector table (one row per clock edge, hand-computed A/B expectations)
//   plus hand-written sequences for reset, full-array readback, output hold and
//   same-edge write/read (expectation depends on RB_WRITE_BYPASS_EN).
module tb_rb_block;

    logic        clk;
    logic        reset;
    logic [23:0] ins;
    logic [7:0]  ans_ex, ans_dm, ans_wb, imm;
    logic [4:0]  rw_dm;
    logic [1:0]  sel_a, sel_b;
    logic        imm_sel;
    logic [7:0]  a, b;

    int n_total;
    int n_pass;

    rb_block dut (
        .clk         (clk),
        .reset       (reset),
        .i_ins       (ins),
        .i_ans_ex    (ans_ex),
        .i_ans_dm    (ans_dm),
        .i_ans_wb    (ans_wb),
        .i_imm       (imm),
        .i_rw_dm     (rw_dm),
        .i_mux_sel_a (sel_a),
        .i_mux_sel_b (sel_b),
        .i_imm_sel   (imm_sel),
        .o_a         (a),
        .o_b         (b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] ins;
        logic [7:0]  ex, dm, wb, imm;
        logic [4:0]  rw;
        logic [1:0]  sa, sb;
        logic        is;
        logic [7:0]  ea, eb;
    } vec_t;

    vec_t vecs [11];

    function automatic vec_t mk(input logic [23:0] i_ins, input logic [7:0] ex, dm, wb, im,
                                input logic [4:0] rw, input logic [1:0] sa, sb,
                                input logic is, input logic [7:0] ea, eb);
        vec_t v;
        v.ins = i_ins; v.ex = ex; v.dm = dm; v.wb = wb; v.imm = im; v.rw = rw;
        v.sa = sa; v.sb = sb; v.is = is; v.ea = ea; v.eb = eb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic idle_inputs();
        ins = '0; ans_ex = '0; ans_dm = '0; ans_wb = '0; imm = '0;
        rw_dm = '0; sel_a = 2'b00; sel_b = 2'b00; imm_sel = 1'b0;
    endtask

    // Advance one edge, then let outputs settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Read every register through the 00 path; rw_dm=0/ans_dm=0 keeps reg0 at zero.
    task automatic read_all_zero(input string tag);
        for (int i = 0; i < 16; i++) begin
            idle_inputs();
            ins = {11'd0, 5'(2 * i), 5'(2 * i + 1), 3'd0};
            step();
            chk($sformatf("%s_reg%0d", tag, 2 * i), a, 8'h00);
            chk($sformatf("%s_reg%0d", tag, 2 * i + 1), b, 8'h00);
        end
    endtask

    initial begin
        logic [7:0] exp_b;
        n_total = 0;
        n_pass  = 0;

        //              ins        ex     dm     wb     imm    rw  sa     sb     is    A      B
        vecs[0]  = mk(24'h000000, 8'h00, 8'h5A, 8'h00, 8'h00, 7,  2'b00, 2'b00, 0, 8'h00, 8'h00);
        vecs[1]  = mk(24'h000700, 8'h00, 8'h12, 8'h00, 8'h00, 12, 2'b00, 2'b00, 0, 8'h5A, 8'h00);
        vecs[2]  = mk(24'h000700, 8'h00, 8'h14, 8'h00, 8'h00, 14, 2'b00, 2'b00, 0, 8'h5A, 8'h00);
        vecs[3]  = mk(24'h000000, 8'h00, 8'h77, 8'h00, 8'h00, 10, 2'b00, 2'b00, 0, 8'h00, 8'h00);
        vecs[4]  = mk(24'h014C50, 8'hC0, 8'hD0, 8'hE0, 8'hFF, 31, 2'b00, 2'b00, 1, 8'h12, 8'hFF);
        vecs[5]  = mk(24'h014E50, 8'hC0, 8'hD0, 8'hE0, 8'hFF, 31, 2'b00, 2'b01, 0, 8'h14, 8'hC0);
        vecs[6]  = mk(24'h014E50, 8'hC0, 8'hD0, 8'hE0, 8'hFF, 31, 2'b11, 2'b10, 0, 8'hE0, 8'hD0);
        vecs[7]  = mk(24'h014E50, 8'hC0, 8'hD0, 8'hE0, 8'hFF, 30, 2'b01, 2'b11, 0, 8'hC0, 8'hE0);
        vecs[8]  = mk(24'h001F50, 8'h00, 8'h00, 8'h00, 8'h00, 0,  2'b00, 2'b00, 0, 8'hD0, 8'h77);
        vecs[9]  = mk(24'h001F50, 8'h00, 8'h21, 8'h00, 8'h3C, 1,  2'b10, 2'b11, 1, 8'h21, 8'h3C);
        vecs[10] = mk(24'hFEE1FF, 8'h00, 8'h00, 8'h00, 8'h00, 0,  2'b00, 2'b00, 0, 8'h21, 8'hD0);

        // Reset for one edge, then release.
        idle_inputs();
        reset = 1'b0;
        step();
        chk("reset_a", a, 8'h00);
        chk("reset_b", b, 8'h00);
        reset = 1'b1;
        read_all_zero("init");

        // Vector table.
        for (int i = 0; i < 11; i++) begin
            ins = vecs[i].ins; ans_ex = vecs[i].ex; ans_dm = vecs[i].dm;
            ans_wb = vecs[i].wb; imm = vecs[i].imm; rw_dm = vecs[i].rw;
            sel_a = vecs[i].sa; sel_b = vecs[i].sb; imm_sel = vecs[i].is;
            step();
            chk($sformatf("vec%0d_a", i), a, vecs[i].ea);
            chk($sformatf("vec%0d_b", i), b, vecs[i].eb);
        end

        // Outputs must not follow inputs between edges (A=0x21, B=0xD0 from vec10).
        ins = 24'h000700; sel_a = 2'b01; ans_ex = 8'h99; imm_sel = 1'b1; imm = 8'h66;
        #3;
        chk("hold_a", a, 8'h21);
        chk("hold_b", b, 8'hD0);

        // Same-edge write and read of reg10 (holds 0x77).
        idle_inputs();
        ins = 24'h000050; rw_dm = 5'd10; ans_dm = 8'h33;
        step();
`ifdef RB_WRITE_BYPASS_EN
        exp_b = 8'h33;
`else
        exp_b = 8'h77;
`endif
        chk("same_edge_b", b, exp_b);
        chk("same_edge_a", a, 8'h00);
        rw_dm = 5'd0; ans_dm = 8'h00;
        step();
        chk("after_write_b", b, 8'h33);

        // Reset coinciding with a write to reg10: write must be dropped.
        rw_dm = 5'd10; ans_dm = 8'h55; sel_a = 2'b11; ans_wb = 8'hAB;
        reset = 1'b0;
        step();
        chk("rst_mid_a", a, 8'h00);
        chk("rst_mid_b", b, 8'h00);
        reset = 1'b1;
        idle_inputs();
        ins = 24'h000050;
        step();
        chk("rst_reg10", b, 8'h00);
        read_all_zero("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
